buzz_arbiter: RTL and testbench
===============================

# buzz_arbiter

Grants one of six debounced player press signals per round to the game logic. It sits between the per-player debounce instances and the game module. It detects press edges and resolves simultaneous presses with a round-robin pointer. It latches the winner's 3-bit value, hands the grant over with a valid/ack handshake, then enforces a lockout hold and a release wait before re-arming.

## Interface
Parameters:
- N_PLAYERS, 6, number of requesters; fixed at 6 for this design, so ID width is 3.
- HOLD_CYCLES, 50_000_000, lockout length after ack (0.5 s at 100 MHz). 0 means no hold.
- TIMER_WIDTH, 26, width of the hold counter. Must satisfy HOLD_CYCLES < 2^TIMER_WIDTH.

Ports:
- clk, in, 1, system clock (100 MHz).
- rst_n, in, 1, reset: asynchronous, active-low.
- req_lvl, in, 6, debounced press levels, bit i = player i+1, active-high.
- player_val, in, 18, packed player values, player i+1 at [3i+2:3i].
- enable, in, 1, arms the arbiter. When low, no new grants are issued.
- grant_valid, out, 1, winner grant pending.
- grant_id, out, 3, winner index 0..5.
- grant_val, out, 3, winner value captured at grant.
- grant_onehot, out, 6, one-hot winner, held until re-arm.
- grant_ack, in, 1, consumer accepts the grant.
- busy, out, 1, high in any state except IDLE.

## Operation
- Edge detect: req_q <= req_lvl every cycle, in all states. edge = req_lvl & ~req_q. Only edges request a grant; a held level never re-requests.
- State IDLE:
  - If enable=1 and edge≠0, select the winner by round-robin search starting at rr_ptr, ascending mod 6.
  - Register grant_id, grant_onehot, and grant_val = player_val slice of the winner, all sampled in the same cycle.
  - Set grant_valid=1 and go to GRANT.
- State GRANT:
  - Hold grant_valid, grant_id and grant_val stable.
  - On grant_ack=1: clear grant_valid, set rr_ptr = (winner+1) mod 6, clear the timer, and go to HOLD. If HOLD_CYCLES=0, go to RELEASE instead.
  - enable is ignored in this state; the handshake always completes.
- State HOLD:
  - Increment the timer each cycle. When timer == HOLD_CYCLES-1, go to RELEASE.
  - If enable=0, go directly to IDLE.
- State RELEASE:
  - When the winner's req_lvl bit is 0, go to IDLE and clear grant_onehot.
  - If enable=0, go directly to IDLE.
- Edges arriving in GRANT, HOLD or RELEASE are discarded. A player still held at re-arm must release and press again.
- grant_ack seen while not in GRANT is ignored.
- Out-of-range rr_ptr cannot occur. The pointer wraps 5→0.
- Reset values: state IDLE; grant_valid 0; grant_id 0; grant_val 0; grant_onehot 0; busy 0; rr_ptr 0; req_q 0; timer 0.
- Reset asserted mid-operation returns the block to IDLE immediately (asynchronous reset). req_q=0 after reset, so a button held through reset produces an edge on the first cycle after release of reset.

## Timing
- Grant latency: req_lvl bit i first sampled high at edge t (req_q still 0) gives grant_valid=1 after edge t. grant_val reflects player_val sampled at edge t.
- Handshake: the transfer occurs at the first edge where grant_valid & grant_ack. grant_valid is 0 after that edge. Holding ack permanently high gives a one-cycle grant_valid pulse.
- Hold length: exactly HOLD_CYCLES cycles in HOLD after the ack edge.
- Release: the edge that samples the winner's bit at 0 moves the block to IDLE. The earliest new grant comes one edge later.
- busy, grant_onehot and grant_id are registered outputs, glitch-free.

## Test plan
- Single press, HOLD_CYCLES=4:
  - Stimulus: req_lvl=000100, player_val slice 2 = 3'd5, ack one cycle after valid.
  - Required: grant_valid rises 1 cycle after the press with grant_id=2, grant_val=5, grant_onehot=000100; 4 cycles in HOLD; IDLE one cycle after req_lvl[2] falls.
- Simultaneous presses:
  - Stimulus: req_lvl 000000→001010 with rr_ptr=0, then after re-arm 001010→ released and re-pressed.
  - Required: first winner id 1, rr_ptr becomes 2; second winner id 3.
- Wrap-around:
  - Stimulus: player 5 wins (rr_ptr becomes 0), then next round players 0 and 5 press together.
  - Required: id 0 wins.
- Lockout discard:
  - Stimulus: player 4 presses during HOLD and stays held through re-arm.
  - Required: no grant. A release and re-press then yields grant_id=4.
- Handshake stall:
  - Stimulus: grant_ack held low for 20 cycles; enable dropped meanwhile.
  - Required: grant_valid/id/val stable for all 20 cycles; after ack, the block goes to HOLD and then immediately to IDLE because enable=0.
- Reset mid-HOLD:
  - Stimulus: rst_n pulsed low.
  - Required: all outputs 0 and rr_ptr 0 asynchronously. A button held through reset produces a grant 1 cycle after rst_n rises (with enable=1).

Source files
------------

// File: rtl/buzz_arbiter.sv
// Buzzer arbiter: grants one of six debounced press edges per round, round-robin on ties,
// then runs a valid/ack handshake, a lockout hold and a wait for the winner to let go.
module buzz_arbiter #(
    parameter int N_PLAYERS   = 6,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int TIMER_WIDTH = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_PLAYERS-1:0]     req_lvl_i,
    input  logic [3*N_PLAYERS-1:0]   player_val_i,
    input  logic                     enable_i,
    input  logic                     grant_ack_i,
    output logic                     grant_valid_o,
    output logic [2:0]               grant_id_o,
    output logic [2:0]               grant_val_o,
    output logic [N_PLAYERS-1:0]     grant_onehot_o,
    output logic                     busy_o
);

    // state   | meaning
    // IDLE    | armed, waiting for a press edge
    // GRANT   | winner presented, waiting for ack
    // HOLD    | lockout timer running
    // RELEASE | waiting for the winner's button to be released
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam int HOLD_LAST_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam logic [TIMER_WIDTH-1:0] HOLD_LAST = TIMER_WIDTH'(HOLD_LAST_I);
    localparam logic [3:0] N_P4 = 4'(N_PLAYERS);

    state_t                   state_q, state_d;
    logic [N_PLAYERS-1:0]     req_q;
    logic [2:0]               rr_ptr_q, rr_ptr_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic                     grant_valid_q, grant_valid_d;
    logic [2:0]               grant_id_q, grant_id_d;
    logic [2:0]               grant_val_q, grant_val_d;
    logic [N_PLAYERS-1:0]     grant_onehot_q, grant_onehot_d;
    logic                     busy_q, busy_d;

    logic [N_PLAYERS-1:0]     req_edge;
    logic [2*N_PLAYERS-1:0]   edge_dbl;
    logic [N_PLAYERS-1:0]     edge_rot;
    logic                     win_found;
    logic [2:0]               rot_off;
    logic [3:0]               win_sum;
    logic [2:0]               win_id;
    logic [N_PLAYERS-1:0]     win_onehot;
    logic [4:0]               val_base;
    logic [2:0]               win_val;
    logic                     hold_done;
    logic                     winner_released;

    assign req_edge = req_lvl_i & ~req_q;

    // Rotate the edge vector so the search always starts at bit 0 from rr_ptr.
    assign edge_dbl = {req_edge, req_edge};
    assign edge_rot = edge_dbl[rr_ptr_q +: N_PLAYERS];

    always_comb begin
        win_found = 1'b0;
        rot_off   = '0;
        for (int k = N_PLAYERS - 1; k >= 0; k--) begin
            if (edge_rot[k]) begin
                win_found = 1'b1;
                rot_off   = 3'(k);
            end
        end
    end

    assign win_sum    = {1'b0, rr_ptr_q} + {1'b0, rot_off};
    assign win_id     = (win_sum >= N_P4) ? 3'(win_sum - N_P4) : win_sum[2:0];
    assign win_onehot = {{(N_PLAYERS-1){1'b0}}, 1'b1} << win_id;
    assign val_base   = {2'b00, win_id} + {1'b0, win_id, 1'b0};
    assign win_val    = player_val_i[val_base +: 3];

    assign hold_done       = (timer_q == HOLD_LAST);
    assign winner_released = ((req_lvl_i & grant_onehot_q) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i && win_found) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (grant_ack_i) begin
                    state_d = (HOLD_CYCLES == 0) ? S_RELEASE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (hold_done) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!enable_i || winner_released) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        timer_d        = timer_q;
        grant_valid_d  = grant_valid_q;
        grant_id_d     = grant_id_q;
        grant_val_d    = grant_val_q;
        grant_onehot_d = grant_onehot_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (enable_i && win_found) begin
                    grant_valid_d  = 1'b1;
                    grant_id_d     = win_id;
                    grant_val_d    = win_val;
                    grant_onehot_d = win_onehot;
                end
            end
            S_GRANT: begin
                if (grant_ack_i) begin
                    grant_valid_d = 1'b0;
                    timer_d       = '0;
                    rr_ptr_d      = (grant_id_q == 3'(N_PLAYERS - 1)) ? 3'd0 : grant_id_q + 3'd1;
                end
            end
            S_HOLD: begin
                timer_d = timer_q + 1'b1;
            end
            default: ;
        endcase
        // The winner mask stays visible until the block is armed again.
        if (state_q != S_IDLE && state_d == S_IDLE) begin
            grant_onehot_d = '0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q          <= '0;
            rr_ptr_q       <= '0;
            timer_q        <= '0;
            grant_valid_q  <= 1'b0;
            grant_id_q     <= '0;
            grant_val_q    <= '0;
            grant_onehot_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            req_q          <= req_lvl_i;
            rr_ptr_q       <= rr_ptr_d;
            timer_q        <= timer_d;
            grant_valid_q  <= grant_valid_d;
            grant_id_q     <= grant_id_d;
            grant_val_q    <= grant_val_d;
            grant_onehot_q <= grant_onehot_d;
            busy_q         <= busy_d;
        end
    end

    assign grant_valid_o  = grant_valid_q;
    assign grant_id_o     = grant_id_q;
    assign grant_val_o    = grant_val_q;
    assign grant_onehot_o = grant_onehot_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Bench for buzz_arbiter: directed press sequences push expected grants into a queue,
// a monitor pops and checks each new grant; timing checks run inline in the stimulus.
module tb_buzz_arbiter;
    localparam int HOLD = 4;
    localparam logic [17:0] PV = {3'd7, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  req_lvl_i = '0;
    logic [17:0] player_val_i = PV;
    logic        enable_i = 1'b1;
    logic        grant_ack_i = 1'b0;
    logic        grant_valid_o;
    logic [2:0]  grant_id_o;
    logic [2:0]  grant_val_o;
    logic [5:0]  grant_onehot_o;
    logic        busy_o;

    typedef struct packed {
        logic [2:0] id;
        logic [2:0] val;
        logic [5:0] oh;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_v = 1'b0;
    logic [2:0] prev_id = '0;
    logic [2:0] prev_val = '0;

    always #5 clk = ~clk;

    buzz_arbiter #(
        .N_PLAYERS  (6),
        .HOLD_CYCLES(HOLD),
        .TIMER_WIDTH(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_lvl_i     (req_lvl_i),
        .player_val_i  (player_val_i),
        .enable_i      (enable_i),
        .grant_ack_i   (grant_ack_i),
        .grant_valid_o (grant_valid_o),
        .grant_id_o    (grant_id_o),
        .grant_val_o   (grant_val_o),
        .grant_onehot_o(grant_onehot_o),
        .busy_o        (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_grant(input logic [2:0] id, input logic [2:0] val, input logic [5:0] oh);
        exp_q.push_back('{id: id, val: val, oh: oh});
    endtask

    // Monitor: a rising grant_valid is a new grant; while it stays high it must not change.
    always @(negedge clk) begin
        if (grant_valid_o && !prev_v) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: got id %0d val %0d, expected no grant", grant_id_o, grant_val_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("grant_id", 32'(grant_id_o), 32'(mon_e.id));
                chk("grant_val", 32'(grant_val_o), 32'(mon_e.val));
                chk("grant_onehot", 32'(grant_onehot_o), 32'(mon_e.oh));
            end
        end else if (grant_valid_o && prev_v) begin
            chk("grant_id_stable", 32'(grant_id_o), 32'(prev_id));
            chk("grant_val_stable", 32'(grant_val_o), 32'(prev_val));
        end
        prev_v   = grant_valid_o;
        prev_id  = grant_id_o;
        prev_val = grant_val_o;
    end

    task automatic do_ack();
        int n = 0;
        while (!grant_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ack_wait_valid", 32'(grant_valid_o), 32'd1);
        grant_ack_i = 1'b1;
        @(negedge clk);
        grant_ack_i = 1'b0;
        chk("ack_clears_valid", 32'(grant_valid_o), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(grant_valid_o), 32'd0);
        chk("rst_id", 32'(grant_id_o), 32'd0);
        chk("rst_val", 32'(grant_val_o), 32'd0);
        chk("rst_onehot", 32'(grant_onehot_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous presses with rr_ptr=0: player 1 wins, then player 3
        req_lvl_i = 6'b001010;
        expect_grant(3'd1, 3'd2, 6'b000010);
        @(negedge clk);
        chk("sim_latency", 32'(grant_valid_o), 32'd1);
        do_ack();
        repeat (8) @(negedge clk);
        chk("release_waits", 32'(busy_o), 32'd1);
        chk("onehot_held", 32'(grant_onehot_o), 32'b000010);
        req_lvl_i = 6'b000000;
        @(negedge clk);
        chk("idle_after_release", 32'(busy_o), 32'd0);
        chk("onehot_cleared", 32'(grant_onehot_o), 32'd0);
        req_lvl_i = 6'b001010;
        expect_grant(3'd3, 3'd3, 6'b001000);
        @(negedge clk);
        chk("rearm_latency", 32'(grant_valid_o), 32'd1);
        do_ack();
        req_lvl_i = '0;
        wait_idle();

        // Single press, value captured at the press edge, hold length
        @(negedge clk);
        req_lvl_i = 6'b000100;
        expect_grant(3'd2, 3'd5, 6'b000100);
        @(negedge clk);
        chk("single_latency", 32'(grant_valid_o), 32'd1);
        player_val_i = '0;
        do_ack();
        req_lvl_i = '0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy_o) cnt++;
            @(negedge clk);
        end
        chk("hold_plus_release_cycles", 32'(cnt), 32'(HOLD + 1));
        player_val_i = PV;

        // Wrap-around: player 5 wins, pointer wraps, then player 0 beats player 5
        req_lvl_i = 6'b100000;
        expect_grant(3'd5, 3'd7, 6'b100000);
        @(negedge clk);
        do_ack();
        req_lvl_i = '0;
        wait_idle();
        @(negedge clk);
        req_lvl_i = 6'b100001;
        expect_grant(3'd0, 3'd1, 6'b000001);
        @(negedge clk);
        chk("wrap_latency", 32'(grant_valid_o), 32'd1);
        do_ack();
        req_lvl_i = '0;
        wait_idle();

        // Lockout: player 4 pressing during HOLD is discarded
        @(negedge clk);
        req_lvl_i = 6'b000010;
        expect_grant(3'd1, 3'd2, 6'b000010);
        @(negedge clk);
        req_lvl_i = '0;
        do_ack();
        req_lvl_i = 6'b010000;
        repeat (12) @(negedge clk);
        chk("lockout_no_grant", 32'(grant_valid_o), 32'd0);
        chk("lockout_idle", 32'(busy_o), 32'd0);
        req_lvl_i = '0;
        @(negedge clk);
        req_lvl_i = 6'b010000;
        expect_grant(3'd4, 3'd6, 6'b010000);
        @(negedge clk);
        chk("repress_latency", 32'(grant_valid_o), 32'd1);
        do_ack();
        req_lvl_i = '0;
        wait_idle();

        // Handshake stall with enable dropped mid-way
        @(negedge clk);
        req_lvl_i = 6'b000001;
        expect_grant(3'd0, 3'd1, 6'b000001);
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            if (k == 5) enable_i = 1'b0;
            chk("stall_valid", 32'(grant_valid_o), 32'd1);
            chk("stall_id", 32'(grant_id_o), 32'd0);
            chk("stall_val", 32'(grant_val_o), 32'd1);
            @(negedge clk);
        end
        do_ack();
        chk("stall_in_hold", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("hold_enable_off_idle", 32'(busy_o), 32'd0);
        chk("hold_enable_off_onehot", 32'(grant_onehot_o), 32'd0);
        req_lvl_i = 6'b000101;
        repeat (3) @(negedge clk);
        chk("disabled_no_grant", 32'(grant_valid_o), 32'd0);
        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_no_regrant", 32'(grant_valid_o), 32'd0);
        req_lvl_i = '0;
        @(negedge clk);

        // Reset mid-HOLD, buttons held through reset
        req_lvl_i = 6'b001000;
        expect_grant(3'd3, 3'd3, 6'b001000);
        @(negedge clk);
        do_ack();
        req_lvl_i = 6'b100010;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(grant_valid_o), 32'd0);
        chk("arst_id", 32'(grant_id_o), 32'd0);
        chk("arst_val", 32'(grant_val_o), 32'd0);
        chk("arst_onehot", 32'(grant_onehot_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_grant(3'd1, 3'd2, 6'b000010);
        @(negedge clk);
        chk("post_reset_latency", 32'(grant_valid_o), 32'd1);
        do_ack();
        req_lvl_i = '0;
        wait_idle();

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
